cache_mem_responder: RTL

//   Main-memory responder for the direct-mapped data cache's line fill/writeback port.

---
 rtl/cache_mem_responder.sv | 110 +++++++++++
 1 files changed

// File: rtl/cache_mem_responder.sv
// Fixed-latency word memory behind the data cache's fill/writeback port.
// One request in flight at a time; results come back as four big-endian bytes and a done pulse.
module cache_mem_responder #(
  parameter int MEM_BYTES     = 8192,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      address_input,
  input  logic             mem_req,
  input  logic             write_en,
  input  logic [0:3][7:0]  mem_data_in,
  output logic [0:3][7:0]  mem_data_out,
  output logic             mem_busy,
  output logic             mem_done
);

  localparam int AW    = $clog2(MEM_BYTES);
  localparam int WORDS = MEM_BYTES / 4;
  localparam int MAXL  = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CW    = (MAXL > 1) ? $clog2(MAXL) : 1;

  localparam logic [CW-1:0] RD_INIT = CW'(READ_LATENCY - 1);
  localparam logic [CW-1:0] WR_INIT = CW'(WRITE_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   count, count_next;
  logic            busy_next, done_next;
  logic            accept, rd_fire, wr_fire;
  logic [AW-3:0]   lat_word;
  logic [0:3][7:0] lat_data;

  logic [0:3][7:0] mem_words [WORDS];

  // Upper address bits wrap away and the byte offset is ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{address_input[31:AW], address_input[1:0]};

  always_comb begin
    state_next = state;
    count_next = count;
    busy_next  = mem_busy;
    done_next  = 1'b0;
    accept     = 1'b0;
    rd_fire    = 1'b0;
    wr_fire    = 1'b0;
    case (state)
      IDLE: begin
        if (mem_req) begin
          accept     = 1'b1;
          busy_next  = 1'b1;
          state_next = write_en ? WR_WAIT : RD_WAIT;
          count_next = write_en ? WR_INIT : RD_INIT;
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (count == '0) begin
          rd_fire    = (state == RD_WAIT);
          wr_fire    = (state == WR_WAIT);
          done_next  = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end else begin
          count_next = count - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Reset aborts any in-flight request; the array itself is never cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      count        <= '0;
      mem_busy     <= 1'b0;
      mem_done     <= 1'b0;
      mem_data_out <= '0;
      lat_word     <= '0;
      lat_data     <= '0;
    end else begin
      state    <= state_next;
      count    <= count_next;
      mem_busy <= busy_next;
      mem_done <= done_next;
      if (accept) begin
        lat_word <= address_input[AW-1:2];
        lat_data <= mem_data_in;
      end
      if (rd_fire) begin
        mem_data_out <= mem_words[lat_word];
      end
    end
  end

  // wr_fire is only possible in WR_WAIT, so an asserted reset suppresses the commit.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_words[lat_word] <= lat_data;
    end
  end

endmodule
